// File: rtl/if_fetch_if.sv
// if_fetch_if: single-outstanding instruction bus between fetch unit and memory
interface if_fetch_if;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  modport master(output ibus_req_o, ibus_addr_o, input ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i);
  modport slave(input ibus_req_o, ibus_addr_o, output ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i);
endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch front end holding one fetched instruction for IF/ID
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stalled,
  input  logic [5:0]        flush,
  input  logic [31:0]       flush_addr_i,
  input  logic              ex_branch_flag_i,
  input  logic [31:0]       ex_branch_addr_i,
  if_fetch_if.master        ibus,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  output logic              stallreq_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n, pc_r, pc_r_n, inst_r, inst_r_n, target;
  logic out_valid, out_valid_n, kill, kill_n, redir, consume, drop, unused;
  assign redir = flush[0] | ex_branch_flag_i;
  assign target = flush[0] ? flush_addr_i : ex_branch_addr_i;
  assign consume = out_valid & ~stalled[0] & ~redir;
  assign drop = kill | redir;
  assign ibus.ibus_req_o = state == REQ;
  assign ibus.ibus_addr_o = state == REQ ? {fetch_pc[31:2], 2'b00} : 32'h0;
  assign pc_o = {pc_r[31:2], 2'b00};
  assign inst_o = out_valid ? inst_r : 32'h0;
  assign stallreq_o = ~out_valid;
  assign unused = ^{stalled[5:1], flush[5:1], pc_r[1:0]};
  // next-state: redirect overrides the PC; a captured response is never blocked by a stall
  always_comb begin
    state_n = state;
    fetch_pc_n = redir ? target : fetch_pc;
    out_valid_n = out_valid & stalled[0] & ~redir;
    kill_n = kill;
    pc_r_n = pc_r;
    inst_r_n = inst_r;
    case (state)
      IDLE: state_n = REQ;
      REQ: if (ibus.ibus_gnt_i) begin
        state_n = WAIT;
        kill_n = redir;
        fetch_pc_n = redir ? target : fetch_pc + PC_STEP;
      end
      WAIT: if (ibus.ibus_rvalid_i) begin
        state_n = drop ? REQ : HOLD;
        kill_n = 1'b0;
        out_valid_n = ~drop;
        pc_r_n = drop ? pc_r : fetch_pc - PC_STEP;
        inst_r_n = drop ? inst_r : ibus.ibus_rdata_i;
      end else if (redir) kill_n = 1'b1;
      HOLD: state_n = (redir | consume) ? REQ : HOLD;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      out_valid <= 1'b0;
      kill <= 1'b0;
      pc_r <= 32'h0;
      inst_r <= 32'h0;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      out_valid <= out_valid_n;
      kill <= kill_n;
      pc_r <= pc_r_n;
      inst_r <= inst_r_n;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: table vectors, directed corner sequences and randomized run against a program-order model
module tb_if_fetch;
  logic clk = 1'b0;
  logic rst;
  logic [5:0] stalled, flush;
  logic [31:0] flush_addr_i, ex_branch_addr_i, pc_o, inst_o;
  logic ex_branch_flag_i, stallreq_o;
  int n_vec = 0, n_bad = 0;
  if_fetch_if bus();
  if_fetch dut (
    .clk(clk), .rst(rst), .stalled(stalled), .flush(flush), .flush_addr_i(flush_addr_i),
    .ex_branch_flag_i(ex_branch_flag_i), .ex_branch_addr_i(ex_branch_addr_i), .ibus(bus),
    .pc_o(pc_o), .inst_o(inst_o), .stallreq_o(stallreq_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic st, g, rv;
    logic [31:0] d;
    logic e_req;
    logic [31:0] e_addr;
    logic e_stall;
    logic [31:0] e_pc, e_inst;
  } vec_t;
  vec_t tbl[16];
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h8) return 32'h0050_0093;
    if (w == 32'h10) return 32'hDEAD_BEEF;
    return ((w * 32'h9E37_79B1) ^ 32'h1357_9BDF) | 32'h1;
  endfunction
  function automatic vec_t mk(input logic st, g, rv, input logic [31:0] d, input logic er,
                              input logic [31:0] ea, input logic es, input logic [31:0] ep, ei);
    vec_t v;
    v.st = st; v.g = g; v.rv = rv; v.d = d;
    v.e_req = er; v.e_addr = ea; v.e_stall = es; v.e_pc = ep; v.e_inst = ei;
    return v;
  endfunction
  function automatic logic [97:0] obs();
    return {bus.ibus_req_o, bus.ibus_req_o ? bus.ibus_addr_o : 32'h0, stallreq_o, pc_o, inst_o};
  endfunction
  task automatic chk(input string nm, input logic [127:0] got, exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic chk5(input string nm, input logic r, input logic [31:0] a, input logic s,
                      input logic [31:0] p, i);
    chk(nm, obs(), {r, a, s, p, i});
  endtask
  task automatic drv(input logic g, rv, input logic [31:0] d, input logic st);
    bus.ibus_gnt_i = g;
    bus.ibus_rvalid_i = rv;
    bus.ibus_rdata_i = d;
    stalled = {5'b0, st};
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    bus.ibus_gnt_i = 1'b0;
    bus.ibus_rvalid_i = 1'b0;
    flush = 6'b0;
    ex_branch_flag_i = 1'b0;
  endtask
  logic pend, valid, held, st0, fl, br;
  int wcnt, rlat, rcnt, gdly, n_del;
  logic [31:0] raddr, exp_pc;
  initial begin
    tbl[0] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[1] = mk(0, 1, 0, 0, 1, 32'h0, 1, 0, 0);
    tbl[2] = mk(0, 0, 1, mem(0), 0, 0, 1, 0, 0);
    tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, mem(0));
    tbl[4] = mk(0, 1, 0, 0, 1, 32'h4, 1, 32'h0, 0);
    tbl[5] = mk(0, 0, 1, mem(4), 0, 0, 1, 32'h0, 0);
    tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 32'h4, mem(4));
    tbl[7] = mk(0, 1, 0, 0, 1, 32'h8, 1, 32'h4, 0);
    tbl[8] = mk(0, 0, 1, mem(8), 0, 0, 1, 32'h4, 0);
    for (int i = 9; i < 14; i++) tbl[i] = mk(1, 0, 0, 0, 0, 0, 0, 32'h8, 32'h0050_0093);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 32'h8, 32'h0050_0093);
    tbl[15] = mk(0, 0, 0, 0, 1, 32'hC, 1, 32'h8, 0);
    rst = 1'b1;
    flush = 6'b0; flush_addr_i = 32'h0; ex_branch_flag_i = 1'b0; ex_branch_addr_i = 32'h0;
    drv(0, 0, 0, 0);
    tick(); tick();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tbl%0d", i), obs(), {tbl[i].e_req, tbl[i].e_addr, tbl[i].e_stall, tbl[i].e_pc, tbl[i].e_inst});
      rst = 1'b0;
      drv(tbl[i].g, tbl[i].rv, tbl[i].d, tbl[i].st);
      tick();
    end
    drv(1, 0, 0, 0); tick();
    chk5("wait_c", 0, 0, 1, 32'h8, 0);
    drv(0, 1, mem(32'hC), 0); tick();
    chk5("hold_c", 0, 0, 0, 32'hC, mem(32'hC));
    tick();
    chk5("req_10", 1, 32'h10, 1, 32'hC, 0);
    drv(1, 0, 0, 0); tick();
    ex_branch_flag_i = 1'b1; ex_branch_addr_i = 32'h100; tick();
    chk5("br_kill", 0, 0, 1, 32'hC, 0);
    tick();
    chk5("br_wait", 0, 0, 1, 32'hC, 0);
    drv(0, 1, 32'hDEAD_BEEF, 0); tick();
    chk5("br_req", 1, 32'h100, 1, 32'hC, 0);
    drv(1, 0, 0, 0); tick();
    drv(0, 1, mem(32'h100), 0); tick();
    chk5("br_hold", 0, 0, 0, 32'h100, mem(32'h100));
    flush = 6'b1; flush_addr_i = 32'h200; ex_branch_flag_i = 1'b1; ex_branch_addr_i = 32'h300; tick();
    chk5("flush_prio", 1, 32'h200, 1, 32'h100, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk5($sformatf("gnt_dly%0d", k), 1, 32'h200, 1, 32'h100, 0);
    end
    drv(1, 0, 0, 0); tick();
    drv(0, 1, mem(32'h200), 0); tick();
    chk5("dly_hold", 0, 0, 0, 32'h200, mem(32'h200));
    tick();
    chk5("req_204", 1, 32'h204, 1, 32'h200, 0);
    drv(1, 0, 0, 0); tick();
    rst = 1'b1; tick();
    chk5("rst_wait", 0, 0, 1, 0, 0);
    rst = 1'b0; tick();
    chk5("rst_req", 1, 32'h0, 1, 0, 0);
    ex_branch_flag_i = 1'b1; ex_branch_addr_i = 32'hFFFF_FFFC; tick();
    chk5("wrap_req", 1, 32'hFFFF_FFFC, 1, 0, 0);
    drv(1, 0, 0, 0); tick();
    drv(0, 1, mem(32'hFFFF_FFFC), 0); tick();
    chk5("wrap_hold", 0, 0, 0, 32'hFFFF_FFFC, mem(32'hFFFF_FFFC));
    tick();
    chk5("wrap_next", 1, 32'h0, 1, 32'hFFFF_FFFC, 0);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    pend = 1'b0; held = 1'b0; rcnt = 0; gdly = 0; wcnt = 0; rlat = 1; raddr = 0;
    exp_pc = 32'h0; n_del = 0;
    for (int c = 0; c < 4000; c++) begin
      valid = !stallreq_o;
      if (valid) begin
        chk("r_pc", pc_o, exp_pc);
        chk("r_inst", inst_o, mem(exp_pc));
        chk("r_noreq", bus.ibus_req_o, 0);
      end else chk("r_bubble", inst_o, 0);
      if (held) chk("r_hold", valid, 1);
      bus.ibus_gnt_i = 1'b0;
      bus.ibus_rvalid_i = 1'b0;
      if (pend) begin
        if (wcnt >= rlat - 1) begin
          bus.ibus_rvalid_i = 1'b1;
          bus.ibus_rdata_i = mem(raddr);
          pend = 1'b0;
        end else wcnt++;
      end else if (bus.ibus_req_o) begin
        if (rcnt >= gdly) begin
          bus.ibus_gnt_i = 1'b1;
          chk("r_addr", bus.ibus_addr_o, {exp_pc[31:2], 2'b00});
          pend = 1'b1; wcnt = 0; raddr = bus.ibus_addr_o;
          rlat = $urandom_range(1, 3); rcnt = 0; gdly = $urandom_range(0, 3);
        end else rcnt++;
      end
      st0 = $urandom_range(0, 9) < 3;
      fl = $urandom_range(0, 24) == 0;
      br = $urandom_range(0, 19) == 0;
      stalled = {5'($urandom), st0};
      flush = {5'($urandom), fl};
      flush_addr_i = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFC : $urandom;
      ex_branch_flag_i = br;
      ex_branch_addr_i = $urandom;
      held = valid && st0 && !(fl || br);
      if (fl || br) exp_pc = (fl ? flush_addr_i : ex_branch_addr_i) & 32'hFFFF_FFFC;
      else if (valid && !st0) begin
        exp_pc = exp_pc + 32'd4;
        n_del++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("liveness", n_del > 50, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
